// File: rtl/dual_port_mem_responder_pkg.sv
// rtl/dual_port_mem_responder_pkg.sv - shared constants and port FSM state encoding
package dual_port_mem_responder_pkg;

  localparam int WORD_SIZE       = 16;
  localparam int ADDR_BITS       = 8;
  localparam int LATENCY_DEFAULT = 3;
  localparam int LATENCY_MIN     = 1;
  localparam int LATENCY_MAX     = 15;
  localparam int CNT_BITS        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } portState_t;

  // Counter preload on accept. A back-to-back accept happens at the edge that
  // ends RESP, so that cycle already counts toward the next access; this keeps
  // the ready-to-ready spacing equal to the latency.
  function automatic logic [CNT_BITS-1:0] firstCount(input int latency, input logic fromResp);
    int n;
    n = fromResp ? latency - 2 : latency - 1;
    if (n < 0) n = 0;
    return CNT_BITS'(n);
  endfunction

endpackage

// File: rtl/dual_port_mem_responder_mem_port_fsm.sv
// rtl/dual_port_mem_responder_mem_port_fsm.sv - per-port request FSM, latency counter and latch
module mem_port_fsm #(
  parameter int WORD_SIZE = dual_port_mem_responder_pkg::WORD_SIZE,
  parameter int ADDR_BITS = dual_port_mem_responder_pkg::ADDR_BITS,
  parameter int LATENCY   = dual_port_mem_responder_pkg::LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readReq,
  input  logic                 writeReq,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [WORD_SIZE-1:0] writeData,
  output logic                 ready,
  output logic                 isWrite,
  output logic [ADDR_BITS-1:0] latchedIndex,
  output logic [WORD_SIZE-1:0] latchedData,
  output logic                 commit,
  output logic                 dualReq
);
  import dual_port_mem_responder_pkg::*;

  // Out-of-range latencies are pulled back into the supported window.
  localparam int LAT_EFF = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                           (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

  portState_t          state;
  logic [CNT_BITS-1:0] cnt;
  logic                request;
  logic                canAccept;

  assign request   = readReq | writeReq;
  assign canAccept = (state == IDLE) || (state == RESP);
  // Read and write together at accept: the write is taken, the top flags it.
  assign dualReq   = canAccept & readReq & writeReq;
  // The edge that ends a write RESP stores the latched word.
  assign commit    = ready & isWrite;

  // Port FSM: accept, count down the latency, one-cycle ready strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ready        <= 1'b0;
      isWrite      <= 1'b0;
      latchedIndex <= '0;
      latchedData  <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (request) begin
            latchedIndex <= address;
            isWrite      <= writeReq;
            if (writeReq) latchedData <= writeData;
            cnt <= firstCount(LAT_EFF, state == RESP);
            if (LAT_EFF == 1) begin
              state <= RESP;
              ready <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (!request) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dual_port_mem_responder.sv
// rtl/dual_port_mem_responder.sv - split I/D bus memory responder with fixed access latency
module dual_port_mem_responder #(
  parameter int WORD_SIZE = dual_port_mem_responder_pkg::WORD_SIZE,
  parameter int ADDR_BITS = dual_port_mem_responder_pkg::ADDR_BITS,
  parameter int LATENCY   = dual_port_mem_responder_pkg::LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_readM,
  input  logic                 i_writeM,
  input  logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 d_ready,
  output logic                 proto_err
);
  import dual_port_mem_responder_pkg::*;

  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];

  logic                 iIsWrite, iCommit, iDualReq;
  logic [ADDR_BITS-1:0] iIndex;
  logic [WORD_SIZE-1:0] iLatchedData;
  logic                 dIsWrite, dCommit, dDualReq;
  logic [ADDR_BITS-1:0] dIndex;
  logic [WORD_SIZE-1:0] dLatchedData;

  logic                 iBypass;
  logic [WORD_SIZE-1:0] iReadData;
  logic                 iDriveEn;
  logic                 dDriveEn;
  logic                 unusedSignals;

  // The instruction port never writes; its write request is tied off.
  mem_port_fsm #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_BITS (ADDR_BITS),
    .LATENCY   (LATENCY)
  ) iPort (
    .clk          (clk),
    .reset_n      (reset_n),
    .readReq      (i_readM),
    .writeReq     (1'b0),
    .address      (i_address[ADDR_BITS-1:0]),
    .writeData    ({WORD_SIZE{1'b0}}),
    .ready        (i_ready),
    .isWrite      (iIsWrite),
    .latchedIndex (iIndex),
    .latchedData  (iLatchedData),
    .commit       (iCommit),
    .dualReq      (iDualReq)
  );

  mem_port_fsm #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_BITS (ADDR_BITS),
    .LATENCY   (LATENCY)
  ) dPort (
    .clk          (clk),
    .reset_n      (reset_n),
    .readReq      (d_readM),
    .writeReq     (d_writeM),
    .address      (d_address[ADDR_BITS-1:0]),
    .writeData    (d_data),
    .ready        (d_ready),
    .isWrite      (dIsWrite),
    .latchedIndex (dIndex),
    .latchedData  (dLatchedData),
    .commit       (dCommit),
    .dualReq      (dDualReq)
  );

  // Storage write at the edge that ends a D-port write response; never reset.
  always_ff @(posedge clk) begin
    if (dCommit) mem[dIndex] <= dLatchedData;
  end

  // Write-first: an I-read answering in the same cycle a D-write commits to
  // the same index sees the new word, not the stale array contents.
  assign iBypass   = i_ready & dCommit & (iIndex == dIndex);
  assign iReadData = iBypass ? dLatchedData : mem[iIndex];

  assign iDriveEn = i_ready & ~iIsWrite;
  assign dDriveEn = d_ready & ~dIsWrite;
  assign i_data   = iDriveEn ? iReadData   : {WORD_SIZE{1'bz}};
  assign d_data   = dDriveEn ? mem[dIndex] : {WORD_SIZE{1'bz}};

  // Sticky protocol error: any I-port write, or D read+write at accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (i_writeM || dDualReq) begin
      proto_err <= 1'b1;
    end
  end

  // Upper address bits wrap by design; the I-port write path is tied off.
  assign unusedSignals = ^{i_address[WORD_SIZE-1:ADDR_BITS], d_address[WORD_SIZE-1:ADDR_BITS],
                           iLatchedData, iCommit, iDualReq};

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// tb/tb_dual_port_mem_responder.sv - randomized self-checking bench for dual_port_mem_responder
module tb_dual_port_mem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_readM, i_writeM;
  logic [15:0] i_address;
  wire  [15:0] i_data;
  logic        i_ready;
  logic        d_readM, d_writeM;
  logic [15:0] d_address;
  wire  [15:0] d_data;
  logic        d_ready;
  logic        proto_err;

  logic        tbDrive;
  logic [15:0] tbWData;

  logic [15:0] model [256];
  int total = 0;
  int bad = 0;

  assign d_data = tbDrive ? tbWData : 16'bz;

  always #5 clk = ~clk;

  dual_port_mem_responder #(
    .WORD_SIZE (16),
    .ADDR_BITS (8),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_readM   (i_readM),
    .i_writeM  (i_writeM),
    .i_address (i_address),
    .i_data    (i_data),
    .i_ready   (i_ready),
    .d_readM   (d_readM),
    .d_writeM  (d_writeM),
    .d_address (d_address),
    .d_data    (d_data),
    .d_ready   (d_ready),
    .proto_err (proto_err)
  );

  task automatic waitReady(input bit dSel, output int n);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (((dSel ? d_ready : i_ready) !== 1'b1) && n < 20);
  endtask

  // One complete access; lat counts edges after the accept edge.
  task automatic access(input bit dSel, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat, output logic [15:0] rdata);
    int n;
    @(negedge clk);
    if (dSel) begin
      d_address = addr; d_readM = !wr; d_writeM = wr; tbDrive = wr; tbWData = wdata;
    end else begin
      i_address = addr; i_readM = 1'b1;
    end
    waitReady(dSel, n);
    lat = n - 1;
    rdata = dSel ? d_data : i_data;
    d_readM = 1'b0; d_writeM = 1'b0; i_readM = 1'b0; tbDrive = 1'b0;
    if (wr) model[addr[7:0]] = wdata;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL reset_i_ready got=%b exp=0", i_ready); end
    total++; if (d_ready !== 1'b0) begin bad++; $display("FAIL reset_d_ready got=%b exp=0", d_ready); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    total++; if (dut.iDriveEn !== 1'b0) begin bad++; $display("FAIL reset_i_bus_z got=%b exp=0", dut.iDriveEn); end
    total++; if (dut.dDriveEn !== 1'b0) begin bad++; $display("FAIL reset_d_bus_z got=%b exp=0", dut.dDriveEn); end
    reset_n = 1'b1;
  endtask

  task automatic test_iread();
    int lat; logic [15:0] rd;
    access(1'b1, 1'b1, 16'h0010, 16'h1234, lat, rd);
    access(1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd);
    total++; if (lat !== LAT) begin bad++; $display("FAIL iread_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL iread_data got=%h exp=1234", rd); end
    @(negedge clk);
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL iread_one_cycle got=%b exp=0", i_ready); end
    total++; if (dut.iDriveEn !== 1'b0) begin bad++; $display("FAIL iread_bus_release got=%b exp=0", dut.iDriveEn); end
  endtask

  task automatic test_write_read_wrap();
    int lat; logic [15:0] rd;
    access(1'b1, 1'b1, 16'h0020, 16'hBEEF, lat, rd);
    total++; if (lat !== LAT) begin bad++; $display("FAIL dwrite_latency got=%0d exp=%0d", lat, LAT); end
    access(1'b1, 1'b0, 16'h0020, 16'h0000, lat, rd);
    total++; if (lat !== LAT) begin bad++; $display("FAIL dread_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL dread_data got=%h exp=beef", rd); end
    access(1'b1, 1'b0, 16'h0120, 16'h0000, lat, rd);
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL dread_wrap got=%h exp=beef", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, n; logic [15:0] rd;
    access(1'b1, 1'b1, 16'h0041, 16'($urandom), lat, rd);
    access(1'b1, 1'b1, 16'h0042, 16'($urandom), lat, rd);
    @(negedge clk);
    i_address = 16'h0041; i_readM = 1'b1;
    waitReady(1'b0, n);
    total++; if (n !== LAT + 1) begin bad++; $display("FAIL b2b_first_wait got=%0d exp=%0d", n, LAT + 1); end
    total++; if (i_data !== model[8'h41]) begin bad++; $display("FAIL b2b_first_data got=%h exp=%h", i_data, model[8'h41]); end
    i_address = 16'h0142;
    waitReady(1'b0, n);
    total++; if (n !== LAT) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", n, LAT); end
    total++; if (i_data !== model[8'h42]) begin bad++; $display("FAIL b2b_second_data got=%h exp=%h", i_data, model[8'h42]); end
    i_readM = 1'b0;
    @(negedge clk);
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", i_ready); end
  endtask

  task automatic test_hazard();
    int lat, n; logic [15:0] rd;
    access(1'b1, 1'b1, 16'h0030, 16'h1111, lat, rd);
    @(negedge clk);
    i_address = 16'h0030; i_readM = 1'b1;
    d_address = 16'h0030; d_writeM = 1'b1; tbDrive = 1'b1; tbWData = 16'h5555;
    waitReady(1'b0, n);
    total++; if (d_ready !== 1'b1) begin bad++; $display("FAIL hazard_same_cycle got=%b exp=1", d_ready); end
    total++; if (i_data !== 16'h5555) begin bad++; $display("FAIL hazard_bypass got=%h exp=5555", i_data); end
    i_readM = 1'b0; d_writeM = 1'b0; tbDrive = 1'b0;
    model[8'h30] = 16'h5555;
    access(1'b1, 1'b0, 16'h0030, 16'h0000, lat, rd);
    total++; if (rd !== 16'h5555) begin bad++; $display("FAIL hazard_stored got=%h exp=5555", rd); end
  endtask

  task automatic test_random();
    int lat, op; logic [15:0] rd, a, w, exp;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      access(1'b1, 1'b1, {8'($urandom), 8'(i)}, w, lat, rd);
      total++; if (lat !== LAT) begin bad++; $display("FAIL rand_preload_lat got=%0d exp=%0d", lat, LAT); end
    end
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 2);
      a = 16'($urandom);
      w = 16'($urandom);
      exp = model[a[7:0]];
      access(op != 0, op == 2, a, w, lat, rd);
      total++; if (lat !== LAT) begin bad++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", op, lat, LAT); end
      if (op != 2) begin
        total++; if (rd !== exp) begin bad++; $display("FAIL rand_read op=%0d addr=%h got=%h exp=%h", op, a, rd, exp); end
      end
    end
  endtask

  task automatic test_abort();
    int lat, seen; logic [15:0] rd, old;
    old = model[8'h50];
    @(negedge clk);
    d_address = 16'h0050; d_writeM = 1'b1; tbDrive = 1'b1; tbWData = ~old;
    repeat (2) @(negedge clk);
    d_writeM = 1'b0; tbDrive = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_ready !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_ready got=%0d exp=0", seen); end
    access(1'b1, 1'b0, 16'h0050, 16'h0000, lat, rd);
    total++; if (rd !== old) begin bad++; $display("FAIL abort_no_commit got=%h exp=%h", rd, old); end
  endtask

  task automatic test_dual_req();
    int n, lat; logic [15:0] rd, w;
    w = 16'($urandom);
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL dual_err_before got=%b exp=0", proto_err); end
    @(negedge clk);
    d_address = 16'h0077; d_readM = 1'b1; d_writeM = 1'b1; tbDrive = 1'b1; tbWData = w;
    waitReady(1'b1, n);
    total++; if (n !== LAT + 1) begin bad++; $display("FAIL dual_latency got=%0d exp=%0d", n, LAT + 1); end
    total++; if (dut.dDriveEn !== 1'b0) begin bad++; $display("FAIL dual_no_drive got=%b exp=0", dut.dDriveEn); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL dual_proto_err got=%b exp=1", proto_err); end
    d_readM = 1'b0; d_writeM = 1'b0; tbDrive = 1'b0;
    model[8'h77] = w;
    access(1'b1, 1'b0, 16'h0077, 16'h0000, lat, rd);
    total++; if (rd !== w) begin bad++; $display("FAIL dual_write_wins got=%h exp=%h", rd, w); end
  endtask

  task automatic test_reset_midrun();
    int lat, seen; logic [15:0] rd, old;
    old = model[8'h60];
    @(negedge clk);
    d_address = 16'h0060; d_writeM = 1'b1; tbDrive = 1'b1; tbWData = ~old;
    i_address = 16'h0061; i_readM = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    d_writeM = 1'b0; i_readM = 1'b0; tbDrive = 1'b0;
    #1;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL midreset_proto_err got=%b exp=0", proto_err); end
    total++; if (dut.iDriveEn !== 1'b0) begin bad++; $display("FAIL midreset_i_bus_z got=%b exp=0", dut.iDriveEn); end
    total++; if (dut.dDriveEn !== 1'b0) begin bad++; $display("FAIL midreset_d_bus_z got=%b exp=0", dut.dDriveEn); end
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (i_ready !== 1'b0 || d_ready !== 1'b0) seen++;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (i_ready !== 1'b0 || d_ready !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_ready_low got=%0d exp=0", seen); end
    access(1'b1, 1'b0, 16'h0060, 16'h0000, lat, rd);
    total++; if (rd !== old) begin bad++; $display("FAIL midreset_no_commit got=%h exp=%h", rd, old); end
  endtask

  task automatic test_iwrite_err();
    int seen;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL iwrite_err_before got=%b exp=0", proto_err); end
    @(negedge clk);
    i_address = 16'h0012; i_writeM = 1'b1;
    @(negedge clk);
    i_writeM = 1'b0;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL iwrite_proto_err got=%b exp=1", proto_err); end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (i_ready !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL iwrite_ignored got=%0d exp=0", seen); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL iwrite_sticky got=%b exp=1", proto_err); end
  endtask

  initial begin
    reset_n = 1'b0;
    i_readM = 1'b0; i_writeM = 1'b0; i_address = '0;
    d_readM = 1'b0; d_writeM = 1'b0; d_address = '0;
    tbDrive = 1'b0; tbWData = '0;
    test_reset();
    test_iread();
    test_write_read_wrap();
    test_back_to_back();
    test_hazard();
    test_random();
    test_abort();
    test_dual_req();
    test_reset_midrun();
    test_iwrite_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
